// File: rtl/ga_pkg.sv
// ga_pkg: shared definitions for the genetic-algorithm datapath.
//   NUM_IND, IND_W, SCORE_W : default population geometry and score width
//   individual_t, score_t   : typed containers for one individual / one score
//   fit_state_t             : fitness_scheduler FSM encoding
package ga_pkg;

    localparam int NUM_IND = 100;
    localparam int IND_W   = 75;
    localparam int SCORE_W = 16;

    typedef logic [IND_W-1:0]   individual_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fit_state_t;

endpackage

// File: rtl/fitness_scheduler_if.sv
// fitness_scheduler_if: handshake between the scheduler and the shared
// fitness evaluator.
//   fit_valid       scheduler -> evaluator  individual presented
//   fit_ready       evaluator -> scheduler  individual accepted
//   fit_ind         scheduler -> evaluator  individual under evaluation
//   fit_score_valid evaluator -> scheduler  one-cycle score strobe
//   fit_score       evaluator -> scheduler  returned score
// master = scheduler side, slave = evaluator side.
interface fitness_scheduler_if #(
    parameter int IND_W   = ga_pkg::IND_W,
    parameter int SCORE_W = ga_pkg::SCORE_W
);
    logic               fit_valid;
    logic               fit_ready;
    logic [IND_W-1:0]   fit_ind;
    logic               fit_score_valid;
    logic [SCORE_W-1:0] fit_score;

    modport master (
        output fit_valid,
        output fit_ind,
        input  fit_ready,
        input  fit_score_valid,
        input  fit_score
    );

    modport slave (
        input  fit_valid,
        input  fit_ind,
        output fit_ready,
        output fit_score_valid,
        output fit_score
    );
endinterface

// File: rtl/fitness_best_tracker.sv
// fitness_best_tracker: running maximum of the scores captured in a pass.
//   clk, rst      clock, asynchronous active-high reset
//   i_clear       pass start: zero best index and best score
//   i_update      a score for i_idx is being captured this cycle
//   i_idx         index of the captured score
//   i_score       captured score (unsigned)
//   o_best_idx    index of the highest score so far (lowest index on ties)
//   o_best_score  highest score so far
module fitness_best_tracker #(
    parameter int IDX_W   = 7,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_update,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [SCORE_W-1:0] i_score,
    output logic [IDX_W-1:0]   o_best_idx,
    output logic [SCORE_W-1:0] o_best_score
);
    logic [IDX_W-1:0]   r_best_idx;
    logic [SCORE_W-1:0] r_best_score;
    logic               w_take;

    // Index 0 always seeds the maximum; afterwards only a strictly larger
    // score wins, so equal scores keep the earlier index.
    assign w_take = i_update && ((i_idx == '0) || (i_score > r_best_score));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_idx   <= '0;
            r_best_score <= '0;
        end else if (i_clear) begin
            r_best_idx   <= '0;
            r_best_score <= '0;
        end else if (w_take) begin
            r_best_idx   <= i_idx;
            r_best_score <= i_score;
        end
    end

    assign o_best_idx   = r_best_idx;
    assign o_best_score = r_best_score;
endmodule

// File: rtl/fitness_scheduler.sv
// fitness_scheduler: runs every individual of a population snapshot through
// one shared fitness evaluator, fills the score table and tracks the best.
//   clk, rst     clock, asynchronous active-high reset
//   start        level request, held high for the whole pass
//   population   packed individuals, individual i = [i*IND_W +: IND_W]
//   fit          evaluator handshake (master side)
//   scores       score table, score i = [i*SCORE_W +: SCORE_W]
//   best_idx     index of the highest score
//   best_score   highest score
//   done         pass complete, held until start drops
//   timeout_err  sticky evaluation timeout (only with the macro)
// Optional feature macro: FITNESS_SCHED_TIMEOUT_EN adds a per-evaluation
// watchdog of TIMEOUT cycles that records a 0 score and sets timeout_err.
module fitness_scheduler
    import ga_pkg::*;
#(
    parameter int NUM_IND = ga_pkg::NUM_IND,
    parameter int IND_W   = ga_pkg::IND_W,
    parameter int SCORE_W = ga_pkg::SCORE_W
`ifdef FITNESS_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_IND*IND_W-1:0]     population,
    fitness_scheduler_if.master          fit,
    output logic [NUM_IND*SCORE_W-1:0]   scores,
    output logic [$clog2(NUM_IND)-1:0]   best_idx,
    output logic [SCORE_W-1:0]           best_score,
    output logic                         done
`ifdef FITNESS_SCHED_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);
    localparam int IDX_W = $clog2(NUM_IND);

    fit_state_t                 r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [NUM_IND*IND_W-1:0]   r_snap;
    logic                       r_fit_valid;
    logic [IND_W-1:0]           r_fit_ind;
    logic [NUM_IND*SCORE_W-1:0] r_scores;
    logic                       r_done;

    logic [IDX_W-1:0]           w_next_idx;
    logic                       w_last;
    logic                       w_clear;
    logic                       w_tmo;
    logic                       w_capture;
    logic [SCORE_W-1:0]         w_cap_score;

`ifdef FITNESS_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]           r_tmo_cnt;
    logic                       r_timeout_err;

    // Fires on the TIMEOUT-th WAIT cycle without a score.
    assign w_tmo       = (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) && !fit.fit_score_valid;
    assign timeout_err = r_timeout_err;
`else
    assign w_tmo       = 1'b0;
`endif

    assign w_next_idx  = r_idx + 1'b1;
    assign w_last      = (r_idx == IDX_W'(NUM_IND - 1));
    assign w_clear     = (r_state == ST_IDLE) && start;
    // Abort (start low) takes priority over a score arriving in the same cycle.
    assign w_capture   = (r_state == ST_WAIT) && start && (fit.fit_score_valid || w_tmo);
    assign w_cap_score = fit.fit_score_valid ? fit.fit_score : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_snap      <= '0;
            r_fit_valid <= 1'b0;
            r_fit_ind   <= '0;
            r_scores    <= '0;
            r_done      <= 1'b0;
`ifdef FITNESS_SCHED_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap      <= population;
                        r_idx       <= '0;
                        r_fit_valid <= 1'b1;
                        r_fit_ind   <= population[0 +: IND_W];
                        r_state     <= ST_ISSUE;
`ifdef FITNESS_SCHED_TIMEOUT_EN
                        r_timeout_err <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (!start) begin
                        r_fit_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (fit.fit_ready) begin
                        r_fit_valid <= 1'b0;
                        r_state     <= ST_WAIT;
`ifdef FITNESS_SCHED_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                    end else if (w_capture) begin
                        r_scores[r_idx*SCORE_W +: SCORE_W] <= w_cap_score;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx       <= w_next_idx;
                            r_fit_valid <= 1'b1;
                            r_fit_ind   <= r_snap[w_next_idx*IND_W +: IND_W];
                            r_state     <= ST_ISSUE;
                        end
`ifdef FITNESS_SCHED_TIMEOUT_EN
                        if (w_tmo) begin
                            r_timeout_err <= 1'b1;
                        end
`endif
                    end else begin
`ifdef FITNESS_SCHED_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    // Holding start high here must not restart the pass.
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fitness_best_tracker #(
        .IDX_W   (IDX_W),
        .SCORE_W (SCORE_W)
    ) u_best (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_update     (w_capture),
        .i_idx        (r_idx),
        .i_score      (w_cap_score),
        .o_best_idx   (best_idx),
        .o_best_score (best_score)
    );

    assign fit.fit_valid = r_fit_valid;
    assign fit.fit_ind   = r_fit_ind;
    assign scores        = r_scores;
    assign done          = r_done;
endmodule

// File: tb/tb_fitness_scheduler.sv
// Directed bench for fitness_scheduler with a four-individual population.
module tb_fitness_scheduler;
    localparam int N  = 4;
    localparam int IW = 75;
    localparam int SW = 16;

    logic                clk;
    logic                rst;
    logic                start;
    logic [N*IW-1:0]     population;
    logic [N*SW-1:0]     scores;
    logic [1:0]          best_idx;
    logic [SW-1:0]       best_score;
    logic                done;
`ifdef FITNESS_SCHED_TIMEOUT_EN
    logic                timeout_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fitness_scheduler_if #(.IND_W(IW), .SCORE_W(SW)) fit_if ();

    fitness_scheduler #(
        .NUM_IND (N),
        .IND_W   (IW),
        .SCORE_W (SW)
`ifdef FITNESS_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT (8)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .population  (population),
        .fit         (fit_if),
        .scores      (scores),
        .best_idx    (best_idx),
        .best_score  (best_score),
        .done        (done)
`ifdef FITNESS_SCHED_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IW-1:0] mk(input int s);
        logic [7:0] b;
        b = s[7:0];
        mk = {s[10:0], {8{b}}};
    endfunction

    task automatic set_pop(input int base);
        for (int i = 0; i < N; i++) population[i*IW +: IW] = mk(base + i);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Acts as the evaluator for one individual: holds ready low for dly
    // cycles, accepts, then returns the score one cycle after acceptance.
    task automatic eval(input string tag, input int dly, input logic [SW-1:0] sc,
                        input logic [IW-1:0] exp_ind);
        int k;
        k = 0;
        while (!fit_if.fit_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, fit_if.fit_valid, 1);
        chk({tag, "_ind"}, fit_if.fit_ind, exp_ind);
        for (int d = 0; d < dly; d++) begin
            fit_if.fit_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_stall_valid"}, fit_if.fit_valid, 1);
            chk({tag, "_stall_ind"}, fit_if.fit_ind, exp_ind);
        end
        fit_if.fit_ready = 1'b1;
        @(negedge clk);
        fit_if.fit_ready = 1'b0;
        chk({tag, "_drop"}, fit_if.fit_valid, 0);
        fit_if.fit_score_valid = 1'b1;
        fit_if.fit_score       = sc;
        @(negedge clk);
        fit_if.fit_score_valid = 1'b0;
    endtask

    initial begin
        int t0;
        logic seen;
        rst = 1'b1;
        start = 1'b0;
        population = '0;
        fit_if.fit_ready = 1'b0;
        fit_if.fit_score_valid = 1'b0;
        fit_if.fit_score = '0;

        // Reset / idle
        @(negedge clk);
        chk("rst_valid", fit_if.fit_valid, 0);
        chk("rst_ind", fit_if.fit_ind, 0);
        chk("rst_scores", scores, 0);
        chk("rst_best_idx", best_idx, 0);
        chk("rst_best_score", best_score, 0);
        chk("rst_done", done, 0);
`ifdef FITNESS_SCHED_TIMEOUT_EN
        chk("rst_tmo", timeout_err, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        set_pop(1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | fit_if.fit_valid;
        end
        chk("idle_no_valid", seen, 0);
        chk("idle_done", done, 0);

        // Full pass, zero-latency evaluator
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < N; i++) eval("full", 0, SW'(i * 10), mk(1 + i));
        chk("full_done", done, 1);
        chk("full_latency", cyc - t0, 9);
        chk("full_scores", scores, {16'd30, 16'd20, 16'd10, 16'd0});
        chk("full_best_idx", best_idx, 3);
        chk("full_best_score", best_score, 30);
        repeat (3) @(negedge clk);
        chk("hold_done", done, 1);
        chk("hold_no_retrigger", fit_if.fit_valid, 0);
        start = 1'b0;
        @(negedge clk);
        chk("drop_done", done, 0);

        // Backpressure and tie
        set_pop(20);
        start = 1'b1;
        eval("bp0", 3, 16'd5, mk(20));
        eval("bp1", 3, 16'd9, mk(21));
        eval("bp2", 3, 16'd9, mk(22));
        eval("bp3", 3, 16'd2, mk(23));
        chk("bp_done", done, 1);
        chk("bp_scores", scores, {16'd2, 16'd9, 16'd9, 16'd5});
        chk("bp_best_idx", best_idx, 1);
        chk("bp_best_score", best_score, 9);
        start = 1'b0;
        @(negedge clk);

        // Abort in WAIT at idx 2, then a late score
        set_pop(40);
        start = 1'b1;
        eval("ab0", 0, 16'd1, mk(40));
        eval("ab1", 0, 16'd2, mk(41));
        t0 = 0;
        while (!fit_if.fit_valid && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        chk("ab2_ind", fit_if.fit_ind, mk(42));
        fit_if.fit_ready = 1'b1;
        @(negedge clk);
        fit_if.fit_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("ab_valid", fit_if.fit_valid, 0);
        chk("ab_done", done, 0);
        fit_if.fit_score_valid = 1'b1;
        fit_if.fit_score = 16'd77;
        @(negedge clk);
        fit_if.fit_score_valid = 1'b0;
        chk("ab_late_scores", scores, {16'd2, 16'd9, 16'd2, 16'd1});
        chk("ab_best_idx", best_idx, 1);
        chk("ab_best_score", best_score, 2);
        chk("ab_idle_valid", fit_if.fit_valid, 0);

        // Restart from idx 0 with population changed mid-pass
        set_pop(60);
        start = 1'b1;
        @(negedge clk);
        chk("rs_best_clear", best_score, 0);
        chk("rs_idx0_valid", fit_if.fit_valid, 1);
        set_pop(90);
        eval("sn0", 0, 16'h7FFF, mk(60));
        eval("sn1", 1, 16'd50,   mk(61));
        eval("sn2", 0, 16'h7FFF, mk(62));
        eval("sn3", 2, 16'h8000, mk(63));
        chk("sn_done", done, 1);
        chk("sn_scores", scores, {16'h8000, 16'h7FFF, 16'd50, 16'h7FFF});
        chk("sn_best_idx", best_idx, 3);
        chk("sn_best_score", best_score, 16'h8000);
        start = 1'b0;
        @(negedge clk);

`ifdef FITNESS_SCHED_TIMEOUT_EN
        // Evaluator never answers idx 1
        set_pop(1);
        start = 1'b1;
        eval("to0", 0, 16'd3, mk(1));
        t0 = 0;
        while (!fit_if.fit_valid && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        chk("to1_ind", fit_if.fit_ind, mk(2));
        fit_if.fit_ready = 1'b1;
        @(negedge clk);
        fit_if.fit_ready = 1'b0;
        repeat (7) @(negedge clk);
        chk("to_pre_err", timeout_err, 0);
        chk("to_pre_valid", fit_if.fit_valid, 0);
        @(negedge clk);
        chk("to_err", timeout_err, 1);
        chk("to_score1", scores[1*SW +: SW], 0);
        eval("to2", 0, 16'd4, mk(3));
        eval("to3", 0, 16'd5, mk(4));
        chk("to_done", done, 1);
        chk("to_err_sticky", timeout_err, 1);
        chk("to_best_idx", best_idx, 3);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("to_err_clear", timeout_err, 0);
        start = 1'b0;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
